// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// requester IDs and a sizing helper. Hazard/stall logic imports this too.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Arbiter FSM states. The DONE states arbitrate exactly like IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_e;

  // Requester identifiers.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Width of a down-counter holding values 0..lat-1 (never narrower than 1).
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable down-counter that times one memory access; zero marks the last
// busy cycle.
module mem_arb_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load takes priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port fixed-latency memory between fetch (instruction reads)
// and the memory stage (data reads/writes). Data has priority, but fetch is
// forced through after STARVE_MAX consecutive data grants while it waits.
//
// Handshake: a requester holds req (and its address/data) high until it sees
// its one-cycle done pulse; a request is granted at a rising edge in IDLE or
// DONE_* when halt=0, and the request fields are latched at that edge, so they
// may change or drop afterwards. Dropping req before a grant cancels it;
// dropping it after a grant does not, and done still pulses. stall = req & ~done.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  localparam int            CW         = cnt_width(LATENCY);
  localparam logic [CW-1:0] LOAD_VAL   = CW'(LATENCY - 1);
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic [15:0]   addr_q, wdata_q;
  logic          wr_q;
  logic [15:0]   if_rdata_q, dm_rdata_q;

  logic          can_grant, fetch_forced, grant_i, grant_d, unaligned;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_val;
  logic          busy;

  // Access timer: loaded on an accepted grant, counts down through BUSY_*.
  mem_arb_lat_cnt #(.W(CW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  // Arbitration: data first unless fetch has been starved to the limit.
  always_comb begin
    can_grant    = ((state_q == IDLE) || (state_q == DONE_I) ||
                    (state_q == DONE_D)) && !halt;
    fetch_forced = if_req && (starve_q == STARVE_SAT);
    grant_d      = can_grant && dm_req && !fetch_forced;
    grant_i      = can_grant && if_req && !grant_d;
    unaligned    = grant_d && dm_addr[0];
  end

  // Next-state, counter control, error flag and starvation bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    err_d    = 1'b0;
    starve_d = starve_q;
    case (state_q)
      IDLE, DONE_I, DONE_D: begin
        if (grant_d) begin
          // A misaligned data address is rejected without touching memory.
          state_d  = unaligned ? IDLE : BUSY_D;
          cnt_load = !unaligned;
          err_d    = unaligned;
        end else if (grant_i) begin
          state_d  = BUSY_I;
          cnt_load = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY_I: begin
        if (cnt_zero) state_d = DONE_I;
        else          cnt_dec = 1'b1;
      end
      BUSY_D: begin
        if (cnt_zero) state_d = DONE_D;
        else          cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (grant_i) begin
      starve_d = '0;
    end else if (grant_d) begin
      if (!if_req)                      starve_d = '0;
      else if (starve_q != STARVE_SAT)  starve_d = starve_q + SW'(1);
    end
  end

  // FSM state, starvation count and error pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  // Latch the winning request; fetch never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_d && !unaligned) begin
      addr_q  <= dm_addr;
      wr_q    <= dm_wr;
      wdata_q <= dm_wdata;
    end else if (grant_i) begin
      addr_q  <= if_addr;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end
  end

  // Capture read data on the last busy cycle; writes leave dm_rdata alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if ((state_q == BUSY_I) && cnt_zero)           if_rdata_q <= mem_rdata;
      if ((state_q == BUSY_D) && cnt_zero && !wr_q)  dm_rdata_q <= mem_rdata;
    end
  end

  // Memory drive, completion pulses and stalls, all decoded from state.
  always_comb begin
    busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
    mem_en    = busy;
    mem_wr    = (state_q == BUSY_D) && wr_q;
    mem_addr  = busy ? addr_q : 16'h0000;
    mem_wdata = ((state_q == BUSY_D) && wr_q) ? wdata_q : 16'h0000;
    if_done   = (state_q == DONE_I);
    dm_done   = (state_q == DONE_D) || err_q;
    err       = err_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    if_stall  = if_req & ~if_done;
    dm_stall  = dm_req & ~dm_done;
    dbg_state = state_q;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares a single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between fetch/memory stages and the memory macro.
- Latches each granted request, drives the memory for LATENCY cycles, returns read data with a one-cycle done pulse, and produces per-requester stall signals for the hazard logic.

Parameters:
LATENCY, 4, memory access cycles per transaction (>=1).
STARVE_MAX, 3, consecutive data grants allowed while fetch is waiting before fetch is forced next (>=1).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
halt  input  1  processor halting; blocks new grants
if_req  input  1  fetch requests an instruction read
if_addr  input  16  fetch address (PC)
if_rdata  output  16  instruction word, valid when if_done
if_done  output  1  one-cycle completion pulse to fetch
if_stall  output  1  if_req & ~if_done
dm_req  input  1  memory stage requests an access
dm_wr  input  1  1 = write, 0 = read
dm_addr  input  16  data address
dm_wdata  input  16  write data
dm_rdata  output  16  load data, valid when dm_done
dm_done  output  1  one-cycle completion pulse to memory stage
dm_stall  output  1  dm_req & ~dm_done
err  output  1  one-cycle pulse: unaligned data address rejected
mem_en  output  1  memory enable
mem_wr  output  1  memory write
mem_addr  output  16  memory address
mem_wdata  output  16  memory write data
mem_rdata  input  16  memory read data, valid in last busy cycle

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D. The DONE states arbitrate exactly like IDLE.
- Reset (rst=0, async): state IDLE, counter 0, starve count 0. All outputs 0: if_rdata, dm_rdata, done, err, mem_*.
- Arbitration (IDLE/DONE_*, halt=0), sampled at the rising edge:
  - Data wins over fetch.
  - Exception: fetch wins if starve count == STARVE_MAX and if_req=1.
- Starve count:
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant, or when if_req=0 at a grant.
  - Saturates at STARVE_MAX.
- Accept: the winner's addr, wr and wdata are latched. State moves to BUSY_I or BUSY_D, counter loads LATENCY-1.
- BUSY_*:
  - mem_en=1; mem_addr/mem_wr/mem_wdata come from the latched registers; fetch always has mem_wr=0.
  - Counter decrements each cycle.
  - At counter==0 the edge captures mem_rdata into if_rdata or dm_rdata (writes leave dm_rdata unchanged) and moves to DONE_*.
- DONE_*:
  - The matching done=1 for exactly one cycle; mem_en=0.
  - A new grant may be made in the same cycle (back-to-back), giving one access per LATENCY+1 cycles.
- Latency: req high at edge T, then done high in cycle T+LATENCY+1 (before edge T+LATENCY+1).
- Rdata registers hold their value until the next completion of the same kind.
- Unaligned data (dm_addr[0]=1) at grant:
  - No memory access; state returns to IDLE.
  - err=1 and dm_done=1 for one cycle in the following cycle; dm_rdata unchanged.
  - Fetch addresses are not checked.
- Withdrawn request: req deasserted before grant means nothing happens.
- req deasserted mid-access: the access completes and done still pulses.
- halt=1: no new grants. An in-flight access completes normally. Deasserting halt resumes arbitration.
- Same requester re-requesting in its DONE cycle is a new, independent access.
- Reset asserted mid-access: immediate abort; IDLE with all outputs 0; memory contents undefined for an aborted write.

Decomposition:
- Shared package: state encoding constants (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D) and the requester-ID encoding (REQ_I=0, REQ_D=1), for reuse by hazard/stall logic.
- One natural sub-module: mem_arb_lat_cnt, a loadable down-counter (load value, decrement, zero flag) sized clog2(LATENCY).
- Arbitration and the FSM stay in the top module.

Test Plan:
- LATENCY=4: if_req=1 alone, if_addr=0x0010, memory holds 0x1234 there -> mem_en for 4 cycles with addr 0x0010, then if_done pulses 1 cycle with if_rdata=0x1234; if_stall=1 until then.
- if_req and dm_req both high; dm read of 0x0020 (holds 0xBEEF) -> data served first (dm_done, dm_rdata=0xBEEF); fetch is granted in the DONE_D cycle and completes 5 cycles later.
- STARVE_MAX=3: dm_req held high with if_req high -> exactly 3 data grants, then a fetch grant, then data again.
- dm_req, dm_wr=1, dm_addr=0x0031 -> no mem_en; err=1 and dm_done=1 for one cycle. Then dm write 0xA5A5 to 0x0030 followed by a read of 0x0030 -> dm_rdata=0xA5A5.
- halt=1 raised during BUSY_D -> the access completes with dm_done; later if_req is never granted (mem_en stays 0) until halt=0.
- rst=0 pulsed in the 2nd busy cycle -> same cycle: state IDLE, mem_en=0, all outputs 0; after release, a fresh fetch completes in LATENCY+1 cycles.
